conv_window_scan_ctrl: RTL and testbench
========================================

// Module: conv_window_scan_ctrl
// PURPOSE
//  Sequences a 3x3 window over the 32x32 8-bit image store for the convolution datapath.
//  Drives cnt/col/row into the image address register; the store then returns one
//  3-pixel column (rows r..r+2) per issue. Tags each returned column for the MAC.
//  Provides start/busy/done control, sink backpressure and abort.
// PARAMETERS
//  IMG_W  32  image width in pixels (columns)
//  IMG_H  32  image height in pixels (rows)
//  K      3   window size; valid output positions are (IMG_H-K+1) x (IMG_W-K+1)
// PORTS
//  clk         in   1  clock
//  rst_n       in   1  asynchronous active-low reset
//  start       in   1  1-cycle pulse; begins a scan when idle, ignored when busy
//  abort       in   1  synchronous; terminates the scan, no done pulse
//  sink_stall  in   1  high = issue no new column on the next edge
//  cnt         out  2  column offset within window (0..K-1) to address register
//  col         out  5  window left column (0..IMG_W-K) to address register
//  row         out  5  window top row (0..IMG_H-K) to address register
//  busy        out  1  scan in progress (SCAN or DRAIN)
//  pix_valid   out  1  image-store outputs hold a column of the current scan this cycle
//  pix_first   out  1  with pix_valid: column is cnt=0 of its window
//  pix_last    out  1  with pix_valid: column is cnt=K-1 (window complete)
//  win_row     out  5  window row of the column on the store outputs
//  win_col     out  5  window col of the column on the store outputs
//  done        out  1  1-cycle pulse, one cycle after the final pix_valid
// BEHAVIOUR
//  Reset: cnt=col=row=0, busy=0, pix_valid=pix_first=pix_last=0, win_row=win_col=0, done=0.
//  States: IDLE -> SCAN on start&!abort; SCAN -> DRAIN on the edge issuing the final tuple;
//   DRAIN -> IDLE after one cycle, done=1 during that IDLE entry cycle; abort -> IDLE from any.
//  Issue: adv = (state==SCAN) & !sink_stall. On an adv edge the current (row,col,cnt) is
//   consumed by the address register and the counters step; pix_valid<=adv (1-cycle latency,
//   matches address register + combinational store). Tags/first/last registered with pix_valid.
//  Backpressure: sink_stall suppresses the next issue only; an already-issued column still
//   appears (pix_valid is never held). Sink must accept every pix_valid cycle.
//  Step order: cnt 0..K-1; on cnt=K-1: cnt=0, col++; col=IMG_W-K wraps to 0 with row++.
//   Final tuple (IMG_H-K, IMG_W-K, K-1); after it counters return to 0,0,0.
//  Total issues per scan: (IMG_H-K+1)*(IMG_W-K+1)*K = 2700 at defaults.
//  Abort: next edge state=IDLE, counters=0, pix_valid/first/last=0 (in-flight column dropped),
//   no done. abort and start in same cycle: abort wins, stays IDLE.
//  start while busy: ignored. start in the done cycle: accepted (state already IDLE).
//  Widths: counters sized $clog2 of their ranges; no arithmetic overflow permitted.
// STRUCTURE
//  Package conv_pkg: IMG_W, IMG_H, K constants, derived widths, scan_state_t enum
//   {IDLE, SCAN, DRAIN}.
//  Sub-module window_counter: nested cnt/col/row counter with enable, clear and
//   last_tuple flag; FSM and output tag pipeline stay in the top.
// TESTING
//  Reset mid-scan -> all outputs at reset values same cycle; cnt/col/row=0 (addr 0/32/64).
//  start, no stall -> 2700 contiguous pix_valid; first (0,0,0) addrs 0/32/64; last (29,29,2)
//   ad1=959; done exactly one cycle after last pix_valid; busy low with done.
//  Random sink_stall (50%) -> still 2700 pix_valid, tuple order identical to no-stall run,
//   no pix_valid in any cycle following a stalled cycle with no prior issue.
//  Row wrap: (row0,col29,cnt2) followed by (row1,col0,cnt0); pix_last tag (0,29), pix_first (1,0).
//  abort at 1000th pix_valid -> no further pix_valid, no done, busy=0 next cycle; restart
//   yields full 2700-column scan from (0,0,0).
//  start while busy -> no effect on sequence; start+abort same cycle from IDLE -> stays IDLE.

Source files
------------

// File: rtl/conv_window_scan_ctrl_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// conv_window_scan_ctrl_pkg : geometry, counter widths and scan states
// Revision: 1.0
// ------------------------------------------------------------------
package conv_window_scan_ctrl_pkg;

  // Width of a counter that holds 0..n-1; never collapses to zero bits.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int K     = 3;

  localparam int COLS  = IMG_W - K + 1;
  localparam int ROWS  = IMG_H - K + 1;

  localparam int CNT_W = width_of(K);
  localparam int COL_W = width_of(COLS);
  localparam int ROW_W = width_of(ROWS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/conv_window_scan_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------
// conv_window_scan_ctrl_if : control, address and column-tag bundle
// Revision: 1.0
// ------------------------------------------------------------------
interface conv_window_scan_ctrl_if;
  import conv_window_scan_ctrl_pkg::*;

  logic             start;
  logic             abort;
  logic             sink_stall;
  logic [CNT_W-1:0] cnt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             busy;
  logic             pix_valid;
  logic             pix_first;
  logic             pix_last;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;
  logic             done;

  modport master (
    output start, abort, sink_stall,
    input  cnt, col, row, busy, pix_valid, pix_first, pix_last,
           win_row, win_col, done
  );

  modport slave (
    input  start, abort, sink_stall,
    output cnt, col, row, busy, pix_valid, pix_first, pix_last,
           win_row, win_col, done
  );
endinterface
`default_nettype wire

// File: rtl/conv_window_scan_ctrl_window_counter.sv
`default_nettype none
// ------------------------------------------------------------------
// conv_window_scan_ctrl_window_counter : nested cnt/col/row stepper
// Revision: 1.0
// ------------------------------------------------------------------
module conv_window_scan_ctrl_window_counter
  import conv_window_scan_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last_tuple
);

  logic w_cnt_end;
  logic w_col_end;
  logic w_row_end;

  assign w_cnt_end  = (cnt == CNT_W'(K - 1));
  assign w_col_end  = (col == COL_W'(COLS - 1));
  assign w_row_end  = (row == ROW_W'(ROWS - 1));
  assign last_tuple = w_cnt_end && w_col_end && w_row_end;

  // The final step wraps every field, so a finished scan leaves 0,0,0 behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      col <= '0;
      row <= '0;
    end else if (clr) begin
      cnt <= '0;
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (w_cnt_end) begin
        cnt <= '0;
        if (w_col_end) begin
          col <= '0;
          row <= w_row_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_window_scan_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// conv_window_scan_ctrl : 3x3 window scan sequencer for the image store
// Revision: 1.0
// ------------------------------------------------------------------
module conv_window_scan_ctrl
  import conv_window_scan_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  conv_window_scan_ctrl_if.slave bus
);

  scan_state_t      r_state;
  logic             r_pix_valid;
  logic             r_pix_first;
  logic             r_pix_last;
  logic [ROW_W-1:0] r_win_row;
  logic [COL_W-1:0] r_win_col;
  logic             r_done;

  logic             w_adv;
  logic             w_last_tuple;
  logic [CNT_W-1:0] w_cnt;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;

  assign w_adv = (r_state == SCAN) && !bus.sink_stall && !bus.abort;

  conv_window_scan_ctrl_window_counter u_window_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (w_adv),
    .clr        (bus.abort),
    .cnt        (w_cnt),
    .col        (w_col),
    .row        (w_row),
    .last_tuple (w_last_tuple)
  );

  assign bus.cnt       = w_cnt;
  assign bus.col       = w_col;
  assign bus.row       = w_row;
  assign bus.busy      = (r_state != IDLE);
  assign bus.pix_valid = r_pix_valid;
  assign bus.pix_first = r_pix_first;
  assign bus.pix_last  = r_pix_last;
  assign bus.win_row   = r_win_row;
  assign bus.win_col   = r_win_col;
  assign bus.done      = r_done;

  // Tags are captured on the issuing edge so they line up with the store's
  // one-cycle address-to-data latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pix_valid <= 1'b0;
      r_pix_first <= 1'b0;
      r_pix_last  <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
      r_done      <= 1'b0;
    end else if (bus.abort) begin
      r_state     <= IDLE;
      r_pix_valid <= 1'b0;
      r_pix_first <= 1'b0;
      r_pix_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_pix_valid <= 1'b0;
      r_pix_first <= 1'b0;
      r_pix_last  <= 1'b0;
      r_done      <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) r_state <= SCAN;
        end
        SCAN: begin
          if (w_adv) begin
            r_pix_valid <= 1'b1;
            r_pix_first <= (w_cnt == '0);
            r_pix_last  <= (w_cnt == CNT_W'(K - 1));
            r_win_row   <= w_row;
            r_win_col   <= w_col;
            if (w_last_tuple) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_scan_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_conv_window_scan_ctrl : randomized bench with a tuple-index reference model
// Revision: 1.0
// ------------------------------------------------------------------
module tb_conv_window_scan_ctrl;

  localparam int W    = 32;
  localparam int H    = 32;
  localparam int KK   = 3;
  localparam int NC   = W - KK + 1;
  localparam int NR   = H - KK + 1;
  localparam int NTUP = NR * NC * KK;

  localparam int M_IDLE  = 0;
  localparam int M_SCAN  = 1;
  localparam int M_DRAIN = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_window_scan_ctrl_if bus ();
  conv_window_scan_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int m_state = M_IDLE;
  int m_idx   = 0;

  logic [26:0] obs_v, exp_v;
  int          rec_addr[$];
  logic [11:0] rec_tag[$];
  int          rec_cyc[$];
  int          done_cnt;
  int          done_cyc;

  // Scan position i enumerates rows outermost, then columns, then window offset.
  function automatic logic [11:0] tup(input int i);
    return {5'(i / (NC * KK)), 5'((i / KK) % NC), 2'(i % KK)};
  endfunction

  function automatic logic [11:0] tagf(input int i);
    int k;
    k = i % KK;
    return {5'(i / (NC * KK)), 5'((i / KK) % NC), (k == 0), (k == KK - 1)};
  endfunction

  task automatic clear_rec();
    rec_addr.delete();
    rec_tag.delete();
    rec_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic step(input bit st, input bit ab, input bit sl);
    logic [11:0] pres;
    bit ev, ed;
    int iss;
    bus.start      = st;
    bus.abort      = ab;
    bus.sink_stall = sl;
    pres = {bus.row, bus.col, bus.cnt};
    ev   = 1'b0;
    ed   = 1'b0;
    iss  = m_idx;
    if (ab) begin
      m_state = M_IDLE;
      m_idx   = 0;
    end else begin
      case (m_state)
        M_IDLE: if (st) m_state = M_SCAN;
        M_SCAN: if (!sl) begin
          ev = 1'b1;
          m_idx++;
          if (m_idx == NTUP) begin
            m_idx   = 0;
            m_state = M_DRAIN;
          end
        end
        default: begin
          m_state = M_IDLE;
          ed      = 1'b1;
        end
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_v = {tup(iss), (m_state != M_IDLE), ev, ed, ev ? tagf(iss) : 12'd0};
    obs_v = {pres, bus.busy, bus.pix_valid, bus.done,
             bus.pix_valid ? {bus.win_row, bus.win_col, bus.pix_first, bus.pix_last} : 12'd0};
    if (bus.pix_valid) begin
      rec_addr.push_back(int'(pres[11:7]) * W + int'(pres[6:2]) + int'(pres[1:0]));
      rec_tag.push_back({bus.win_row, bus.win_col, bus.pix_first, bus.pix_last});
      rec_cyc.push_back(cyc);
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.sink_stall = 1'b0;
    #3;
    checks++;
    if ({bus.cnt, bus.col, bus.row, bus.busy, bus.pix_valid, bus.pix_first, bus.pix_last,
         bus.win_row, bus.win_col, bus.done} !== 27'd0) begin
      errors++;
      $display("FAIL reset_values got=%h exp=0", {bus.cnt, bus.col, bus.row, bus.busy,
               bus.pix_valid, bus.pix_first, bus.pix_last, bus.win_row, bus.win_col, bus.done});
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_state = M_IDLE;
    m_idx = 0;
  endtask

  task automatic test_full_scan();
    int guard = 0;
    clear_rec();
    step(1, 0, 0);
    checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL full_scan_start got=%h exp=%h", obs_v, exp_v); end
    while (done_cnt == 0 && guard < NTUP + 100) begin
      step(0, 0, 0);
      guard++;
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL full_scan cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL full_scan_done got=%0d exp=1", done_cnt); end
    checks++;
    if (rec_cyc.size() != NTUP) begin
      errors++; $display("FAIL full_scan_count got=%0d exp=%0d", rec_cyc.size(), NTUP);
    end else begin
      checks++;
      if (rec_cyc[NTUP-1] - rec_cyc[0] != NTUP - 1) begin
        errors++; $display("FAIL full_scan_contig got=%0d exp=%0d", rec_cyc[NTUP-1] - rec_cyc[0], NTUP - 1);
      end
      checks++;
      if ({rec_addr[0], rec_addr[0] + W, rec_addr[0] + 2 * W} != {32'd0, 32'd32, 32'd64}) begin
        errors++; $display("FAIL first_addr got=%0d exp=0", rec_addr[0]);
      end
      checks++;
      if (rec_addr[NTUP-1] != 959) begin
        errors++; $display("FAIL last_addr got=%0d exp=959", rec_addr[NTUP-1]);
      end
      checks++;
      if (done_cyc - rec_cyc[NTUP-1] != 1) begin
        errors++; $display("FAIL done_latency got=%0d exp=1", done_cyc - rec_cyc[NTUP-1]);
      end
    end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_with_done got=%b exp=0", bus.busy); end
  endtask

  task automatic test_row_wrap();
    int guard = 0;
    clear_rec();
    step(1, 0, 0);
    while (rec_tag.size() < 92 && guard < 1000) begin
      step(0, 0, ($urandom_range(0, 9) < 3));
      guard++;
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL row_wrap cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    checks++;
    if (rec_tag.size() < 92) begin
      errors++; $display("FAIL row_wrap_timeout got=%0d exp=92", rec_tag.size());
    end else begin
      checks++;
      if (rec_tag[89] !== {5'd0, 5'd29, 1'b0, 1'b1}) begin
        errors++; $display("FAIL row_wrap_last got=%h exp=%h", rec_tag[89], {5'd0, 5'd29, 1'b0, 1'b1});
      end
      checks++;
      if (rec_tag[90] !== {5'd1, 5'd0, 1'b1, 1'b0}) begin
        errors++; $display("FAIL row_wrap_first got=%h exp=%h", rec_tag[90], {5'd1, 5'd0, 1'b1, 1'b0});
      end
    end
    step(0, 1, 0);
    checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL row_wrap_abort got=%h exp=%h", obs_v, exp_v); end
  endtask

  task automatic test_random_stall();
    int guard = 0;
    bit prev_stall = 1'b0;
    bit sl;
    clear_rec();
    step(1, 0, 0);
    while (done_cnt == 0 && guard < 4 * NTUP) begin
      sl = ($urandom_range(0, 1) == 1);
      step(0, 0, sl);
      guard++;
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL rand_stall cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
      if (sl) begin
        checks++;
        if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL stall_issue got=%b exp=0", bus.pix_valid); end
      end
      prev_stall = sl;
    end
    checks++;
    if (rec_tag.size() != NTUP || done_cnt != 1) begin
      errors++; $display("FAIL rand_stall_count got=%0d/%0d exp=%0d/1", rec_tag.size(), done_cnt, NTUP);
    end
  endtask

  task automatic test_abort_restart();
    int guard = 0;
    int nv;
    clear_rec();
    step(1, 0, 0);
    while (rec_tag.size() < 1000 && guard < 4 * NTUP) begin
      step(0, 0, ($urandom_range(0, 1) == 1));
      guard++;
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL abort_run cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    nv = rec_tag.size();
    step(0, 1, ($urandom_range(0, 1) == 1));
    checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL abort_edge got=%h exp=%h", obs_v, exp_v); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    for (int i = 0; i < 20; i++) begin
      step(0, 0, ($urandom_range(0, 1) == 1));
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL abort_idle cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    checks++;
    if (nv != 1000 || rec_tag.size() != nv || done_cnt != 0) begin
      errors++; $display("FAIL abort_quiet got=%0d/%0d/%0d exp=1000/1000/0", nv, rec_tag.size(), done_cnt);
    end
    clear_rec();
    guard = 0;
    step(1, 0, 0);
    while (done_cnt == 0 && guard < NTUP + 100) begin
      step(0, 0, 0);
      guard++;
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL restart cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    checks++;
    if (rec_tag.size() != NTUP || rec_tag[0] !== {5'd0, 5'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL restart_scan got=%0d/%h exp=%0d/%h", rec_tag.size(), rec_tag[0], NTUP, {5'd0, 5'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_start_busy();
    int guard = 0;
    clear_rec();
    step(1, 0, 0);
    while (done_cnt == 0 && guard < 2 * NTUP) begin
      step(($urandom_range(0, 3) == 0), 0, ($urandom_range(0, 2) == 0));
      guard++;
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL start_busy cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    checks++;
    if (rec_tag.size() != NTUP) begin
      errors++; $display("FAIL start_busy_count got=%0d exp=%0d", rec_tag.size(), NTUP);
    end
    step(0, 0, 0);
  endtask

  task automatic test_start_abort_idle();
    step(1, 1, 0);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_abort_busy got=%b exp=0", bus.busy); end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0);
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL start_abort cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    clear_rec();
    step(1, 0, 0);
    while (done_cnt == 0 && guard < 2 * NTUP) begin
      step(0, 0, ($urandom_range(0, 4) == 0));
      guard++;
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL b2b_first cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    clear_rec();
    guard = 0;
    step(1, 0, 0);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_start_in_done got=%b exp=1", bus.busy); end
    while (done_cnt == 0 && guard < NTUP + 100) begin
      step(0, 0, 0);
      guard++;
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL b2b_second cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    checks++;
    if (rec_tag.size() != NTUP) begin
      errors++; $display("FAIL b2b_count got=%0d exp=%0d", rec_tag.size(), NTUP);
    end
  endtask

  task automatic test_reset_mid_scan();
    step(1, 0, 0);
    for (int i = 0; i < 500; i++) begin
      step(0, 0, ($urandom_range(0, 1) == 1));
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL pre_reset cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.cnt, bus.col, bus.row, bus.busy, bus.pix_valid, bus.pix_first, bus.pix_last,
         bus.win_row, bus.win_col, bus.done} !== 27'd0) begin
      errors++;
      $display("FAIL mid_reset got=%h exp=0", {bus.cnt, bus.col, bus.row, bus.busy,
               bus.pix_valid, bus.pix_first, bus.pix_last, bus.win_row, bus.win_col, bus.done});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_state = M_IDLE;
    m_idx = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_row_wrap();
    test_random_stall();
    test_abort_restart();
    test_start_busy();
    test_start_abort_idle();
    test_back_to_back();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
